// File: rtl/reset_sequencer.sv
// Staged reset sequencer: holds memory, core and peripheral resets low, then releases them in order.
// Optional cause register and rst_cause_o port are built when RESET_CAUSE_EN is defined.
module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned STAGE_DELAY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_rst_req_i,
    input  logic       wdt_rst_i,
    output logic [2:0] stage_rst_n_o,
    output logic       seq_done_o,
    output logic       sw_rst_ack_o
`ifdef RESET_CAUSE_EN
    ,
    output logic [1:0] rst_cause_o
`endif
);

    localparam int unsigned MAX_CYCLES = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    localparam logic [2:0] STAGES_NONE = 3'b000;
    localparam logic [2:0] STAGES_MEM  = 3'b001;
    localparam logic [2:0] STAGES_CORE = 3'b011;
    localparam logic [2:0] STAGES_ALL  = 3'b111;

`ifdef RESET_CAUSE_EN
    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;
`endif

    typedef enum logic [1:0] {
        S_HOLD,
        S_REL0,
        S_REL1,
        S_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       stage_q, stage_d;
    logic             done_q,  done_d;
    logic             ack_q,   ack_d;
`ifdef RESET_CAUSE_EN
    logic [1:0]       cause_q, cause_d;
`endif

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        stage_d = stage_q;
        done_d  = done_q;
        ack_d   = 1'b0;
`ifdef RESET_CAUSE_EN
        cause_d = cause_q;
`endif

        unique case (state_q)
            S_HOLD: begin
                if (wdt_rst_i) begin
                    cnt_d   = CNT_ZERO;
                    stage_d = STAGES_NONE;
`ifdef RESET_CAUSE_EN
                    cause_d = CAUSE_WDT;
`endif
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_REL0;
                    stage_d = STAGES_MEM;
                    cnt_d   = CNT_ZERO;
                end
            end

            S_REL0: begin
                if (wdt_rst_i) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_ZERO;
                    stage_d = STAGES_NONE;
`ifdef RESET_CAUSE_EN
                    cause_d = CAUSE_WDT;
`endif
                end else if (cnt_q == STAGE_LAST) begin
                    state_d = S_REL1;
                    stage_d = STAGES_CORE;
                    cnt_d   = CNT_ZERO;
                end
            end

            S_REL1: begin
                if (wdt_rst_i) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_ZERO;
                    stage_d = STAGES_NONE;
`ifdef RESET_CAUSE_EN
                    cause_d = CAUSE_WDT;
`endif
                end else if (cnt_q == STAGE_LAST) begin
                    state_d = S_RUN;
                    stage_d = STAGES_ALL;
                    done_d  = 1'b1;
                    cnt_d   = CNT_ZERO;
                end
            end

            S_RUN: begin
                // The counter parks in RUN so it needs no clear when a request arrives.
                cnt_d = cnt_q;
                if (wdt_rst_i || sw_rst_req_i) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_ZERO;
                    stage_d = STAGES_NONE;
                    done_d  = 1'b0;
                    ack_d   = sw_rst_req_i;
`ifdef RESET_CAUSE_EN
                    cause_d = wdt_rst_i ? CAUSE_WDT : CAUSE_SW;
`endif
                end
            end

            default: begin
                state_d = S_HOLD;
                cnt_d   = CNT_ZERO;
                stage_d = STAGES_NONE;
                done_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HOLD;
            cnt_q   <= CNT_ZERO;
            stage_q <= STAGES_NONE;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
`ifdef RESET_CAUSE_EN
            cause_q <= CAUSE_POR;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
`ifdef RESET_CAUSE_EN
            cause_q <= cause_d;
`endif
        end
    end

    assign stage_rst_n_o = stage_q;
    assign seq_done_o    = done_q;
    assign sw_rst_ack_o  = ack_q;
`ifdef RESET_CAUSE_EN
    assign rst_cause_o   = cause_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: vector table applied through a scoreboard queue,
// plus hand-written reset and asynchronous-reset sequences.
module tb_reset_sequencer;

    localparam int H = 8;
    localparam int S = 4;

    logic       clk;
    logic       rst_n;
    logic       sw_rst_req_i;
    logic       wdt_rst_i;
    logic [2:0] stage_rst_n_o;
    logic       seq_done_o;
    logic       sw_rst_ack_o;
`ifdef RESET_CAUSE_EN
    logic [1:0] rst_cause_o;
`endif

    reset_sequencer #(
        .HOLD_CYCLES (H),
        .STAGE_DELAY (S)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw_rst_req_i  (sw_rst_req_i),
        .wdt_rst_i     (wdt_rst_i),
        .stage_rst_n_o (stage_rst_n_o),
        .seq_done_o    (seq_done_o),
        .sw_rst_ack_o  (sw_rst_ack_o)
`ifdef RESET_CAUSE_EN
        ,
        .rst_cause_o   (rst_cause_o)
`endif
    );

    typedef struct {
        logic       sw;
        logic       wdt;
        logic [2:0] stage;
        logic       done;
        logic       ack;
        logic [1:0] cause;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int vec_idx  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic sw, input logic wdt, input logic [2:0] st,
                                input logic d, input logic a, input logic [1:0] c);
        vec_t v;
        v.sw    = sw;
        v.wdt   = wdt;
        v.stage = st;
        v.done  = d;
        v.ack   = a;
        v.cause = c;
        tbl.push_back(v);
    endfunction

    // Expected stage pattern k edges into a sequence (edge 1 = first edge after HOLD entry).
    function automatic logic [2:0] stage_at(input int k);
        if (k >= H + 2 * S) return 3'b111;
        if (k >= H + S)     return 3'b011;
        if (k >= H)         return 3'b001;
        return 3'b000;
    endfunction

    function automatic void add_seq(input logic sw, input logic wdt, input int n, input logic [1:0] c);
        for (int k = 1; k <= n; k++) begin
            add(sw, wdt, stage_at(k), (k >= H + 2 * S), 1'b0, c);
        end
    endfunction

    function automatic void add_run_idle(input int n, input logic [1:0] c);
        for (int k = 0; k < n; k++) begin
            add(1'b0, 1'b0, 3'b111, 1'b1, 1'b0, c);
        end
    endfunction

    // Called at a negedge; drives one vector, compares just after the next posedge, returns at the following negedge.
    task automatic apply(input vec_t v);
        vec_t e;
        sw_rst_req_i = v.sw;
        wdt_rst_i    = v.wdt;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("v%0d stage", vec_idx), 8'(stage_rst_n_o), 8'(e.stage));
        check($sformatf("v%0d done", vec_idx),  8'(seq_done_o),    8'(e.done));
        check($sformatf("v%0d ack", vec_idx),   8'(sw_rst_ack_o),  8'(e.ack));
`ifdef RESET_CAUSE_EN
        check($sformatf("v%0d cause", vec_idx), 8'(rst_cause_o),   8'(e.cause));
`endif
        vec_idx++;
        @(negedge clk);
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end
        tbl.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " stage"}, 8'(stage_rst_n_o), 8'h00);
        check({tag, " done"},  8'(seq_done_o),    8'h00);
        check({tag, " ack"},   8'(sw_rst_ack_o),  8'h00);
`ifdef RESET_CAUSE_EN
        check({tag, " cause"}, 8'(rst_cause_o),   8'h00);
`endif
    endtask

    initial begin
        rst_n        = 1'b1;
        sw_rst_req_i = 1'b0;
        wdt_rst_i    = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("por_async");

        // Requests during reset have no effect.
        sw_rst_req_i = 1'b1;
        wdt_rst_i    = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("por_held");

        @(negedge clk);
        sw_rst_req_i = 1'b0;
        wdt_rst_i    = 1'b0;
        rst_n        = 1'b1;

        // Power-on release, then idle in RUN.
        add_seq(1'b0, 1'b0, H + 2 * S, 2'b00);
        add_run_idle(2, 2'b00);
        // One-cycle software request and full re-release.
        add(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'b01);
        add_seq(1'b0, 1'b0, H + 2 * S, 2'b01);
        // Software and watchdog together: ack still pulses, watchdog wins the cause.
        add(1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 2'b10);
        add_seq(1'b0, 1'b0, H + 2 * S, 2'b10);
        // Software request, then watchdog while in REL1 restarts the timing.
        add(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'b01);
        add_seq(1'b0, 1'b0, H + S, 2'b01);
        add(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 2'b10);
        add_seq(1'b0, 1'b0, H + 2 * S, 2'b10);
        // Software request held high: one ack per completed sequence.
        add(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'b01);
        add_seq(1'b1, 1'b0, H + 2 * S, 2'b01);
        add(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'b01);
        add_seq(1'b0, 1'b0, H + 2 * S, 2'b01);
        add_run_idle(1, 2'b01);
        run_table();

        // Asynchronous reset between edges while in RUN.
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_run");
        sw_rst_req_i = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("async_held");

        @(negedge clk);
        sw_rst_req_i = 1'b0;
        rst_n        = 1'b1;
        add_seq(1'b0, 1'b0, H + 2 * S, 2'b00);
        add_run_idle(1, 2'b00);
        run_table();

        check("scoreboard empty", 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 8: cycles all stages are held in reset before the first release (must be >=1).
REQ-002 SHALL have parameter STAGE_DELAY, default 4: cycles between consecutive stage releases (must be >=1).
REQ-003 SHALL have port clk  input  1  system clock; the single clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low; driven by the conditioned, clock-aligned reset output.
REQ-005 SHALL have port sw_rst_req_i  input  1  software reset request, level, synchronous to clk.
REQ-006 SHALL have port wdt_rst_i  input  1  watchdog reset request, level, synchronous to clk.
REQ-007 SHALL have port stage_rst_n_o  output  3  per-stage active-low resets: bit0 memory, bit1 core, bit2 peripherals.
REQ-008 SHALL have port seq_done_o  output  1  high while all stages are released.
REQ-009 SHALL have port sw_rst_ack_o  output  1  one-cycle pulse when a software request is accepted.
REQ-010 SHALL have port rst_cause_o  output  2  cause of the last sequence: 00 POR, 01 SW, 10 WDT (present only with RESET_CAUSE_EN).

Function
REQ-011 SHALL implement FSM states HOLD, REL0, REL1, RUN with one counter, width clog2(max(HOLD_CYCLES,STAGE_DELAY))+1.
REQ-012 HOLD: stage_rst_n_o=000; counter increments each edge; on the edge where counter==HOLD_CYCLES-1, go to REL0, set stage_rst_n_o=001, clear counter.
REQ-013 REL0: on the edge where counter==STAGE_DELAY-1, go to REL1, set stage_rst_n_o=011, clear counter.
REQ-014 REL1: on the edge where counter==STAGE_DELAY-1, go to RUN, set stage_rst_n_o=111, seq_done_o=1.
REQ-015 Timing from edge 1 (first rising edge with rst_n high): bit0 rises at edge HOLD_CYCLES, bit1 at HOLD_CYCLES+STAGE_DELAY, bit2 and seq_done_o at HOLD_CYCLES+2*STAGE_DELAY; defaults give edges 8, 12, 16.
REQ-016 RUN: on an edge with wdt_rst_i or sw_rst_req_i high, go to HOLD, drive stage_rst_n_o=000 and seq_done_o=0 on that same edge, clear counter.
REQ-017 sw_rst_ack_o SHALL pulse high for exactly the one cycle following acceptance in RUN, including when wdt_rst_i is high simultaneously.
REQ-018 wdt_rst_i high in HOLD, REL0 or REL1 SHALL restart the sequence: go to HOLD, set all stages to 0, clear counter.
REQ-019 sw_rst_req_i outside RUN SHALL be ignored, with no ack; a request still held when RUN is re-entered is accepted again.
REQ-020 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-021 While rst_n is low: state HOLD, counter 0, stage_rst_n_o=000, seq_done_o=0, sw_rst_ack_o=0, rst_cause_o=00, all asynchronously.
REQ-022 rst_n asserted mid-sequence or in RUN SHALL force the REQ-021 values immediately, without waiting for a clock edge.

Configuration
REQ-023 Macro RESET_CAUSE_EN defined: rst_cause_o is present and is updated on the edge entering HOLD from a request (WDT takes priority over SW); it holds its value otherwise and is cleared only by rst_n.
REQ-024 Macro RESET_CAUSE_EN undefined: the rst_cause_o port and its register are absent; all other behaviour is identical.

Verification
REQ-025 Release rst_n, inputs 0, defaults -> stage_rst_n_o 001 at edge 8, 011 at edge 12, 111 plus seq_done_o=1 at edge 16.
REQ-026 In RUN, 1-cycle sw_rst_req_i -> stages 000 on that edge; sw_rst_ack_o one pulse; rst_cause_o=01; full re-release after 8/12/16 edges.
REQ-027 In RUN, sw_rst_req_i and wdt_rst_i high together -> sw_rst_ack_o pulses and rst_cause_o=10.
REQ-028 wdt_rst_i pulse while in REL1 (stage_rst_n_o=011) -> next edge 000; release timing restarts from 0.
REQ-029 rst_n low asynchronously, between edges, while in RUN -> all outputs 0 before the next edge; rst_cause_o=00.
REQ-030 sw_rst_req_i held high continuously -> one ack per completed sequence; no ack during HOLD, REL0 or REL1.
